// File: rtl/ram_model.sv
// Single-port word memory: self-fills with a pattern after reset, then serves one request per cycle.
// Reads return in order after READ_LATENCY cycles as an ack pulse. There is no backpressure.
module ram_model #(
  parameter int ADDR_SIZE    = 13,
  parameter int WORD_SIZE    = 16,
  parameter int READ_LATENCY = 2,
  parameter int INIT_PATTERN = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ram_avalid,
  input  logic                 ram_rnw,
  input  logic [ADDR_SIZE-1:0] ram_addr,
  input  logic [WORD_SIZE-1:0] ram_wdata,
  output logic [WORD_SIZE-1:0] ram_rdata,
  output logic                 ram_ack,
  output logic                 init_done,
  output logic                 req_dropped
);

  localparam int DEPTH = 1 << ADDR_SIZE;

  typedef enum logic {ST_INIT, ST_READY} state_t;

  state_t                 state_q, state_d;
  logic [ADDR_SIZE:0]     init_addr_q, init_addr_d;
  logic                   req_dropped_q, req_dropped_d;

  logic [WORD_SIZE-1:0]   mem [DEPTH];
  logic                   mem_we;
  logic [ADDR_SIZE-1:0]   mem_waddr;
  logic [WORD_SIZE-1:0]   mem_wdata;
  logic                   rd_fire;

  logic [READ_LATENCY-1:0] vld_q;
  logic [WORD_SIZE-1:0]    dat_q [READ_LATENCY];

  function automatic logic [WORD_SIZE-1:0] pattern_word(input logic [ADDR_SIZE-1:0] a);
    logic [ADDR_SIZE+WORD_SIZE-1:0] ext;
    ext = {{WORD_SIZE{1'b0}}, a};
    return (INIT_PATTERN == 1) ? ext[WORD_SIZE-1:0] : '0;
  endfunction

  always_comb begin
    state_d       = state_q;
    init_addr_d   = init_addr_q;
    req_dropped_d = req_dropped_q;
    mem_we        = 1'b0;
    mem_waddr     = ram_addr;
    mem_wdata     = ram_wdata;
    rd_fire       = 1'b0;
    case (state_q)
      ST_INIT: begin
        mem_we      = 1'b1;
        mem_waddr   = init_addr_q[ADDR_SIZE-1:0];
        mem_wdata   = pattern_word(init_addr_q[ADDR_SIZE-1:0]);
        init_addr_d = init_addr_q + (ADDR_SIZE+1)'(1);
        // The extra counter bit flags that the last address has just been written.
        if (init_addr_d[ADDR_SIZE]) state_d = ST_READY;
        if (ram_avalid) req_dropped_d = 1'b1;
      end
      ST_READY: begin
        mem_we  = ram_avalid & ~ram_rnw;
        rd_fire = ram_avalid & ram_rnw;
      end
      default: state_d = ST_INIT;
    endcase
    if (reset) mem_we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_INIT;
      init_addr_q   <= '0;
      req_dropped_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      init_addr_q   <= init_addr_d;
      req_dropped_q <= req_dropped_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // The final stage only loads on a valid read, so it holds the last delivered word.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      for (int i = 0; i < READ_LATENCY; i++) dat_q[i] <= '0;
    end else begin
      vld_q[0] <= rd_fire;
      if (rd_fire || READ_LATENCY > 1) dat_q[0] <= mem[ram_addr];
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1] || i < READ_LATENCY - 1) dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign ram_ack     = vld_q[READ_LATENCY-1];
  assign ram_rdata   = dat_q[READ_LATENCY-1];
  assign init_done   = (state_q == ST_READY);
  assign req_dropped = req_dropped_q;

endmodule

// File: tb/tb_ram_model.sv
// Bench for ram_model: directed vector table and corner sequences, plus random traffic
// checked against a queue-based reference model.
module tb_ram_model;
  localparam int AW    = 13;
  localparam int WW    = 16;
  localparam int L     = 2;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          avalid = 1'b0;
  logic          rnw = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [WW-1:0] wdata = '0;
  logic [WW-1:0] ram_rdata;
  logic          ram_ack;
  logic          init_done;
  logic          req_dropped;

  always #5 clk = ~clk;

  ram_model #(
    .ADDR_SIZE(AW), .WORD_SIZE(WW), .READ_LATENCY(L), .INIT_PATTERN(1)
  ) dut (
    .clk(clk), .reset(rst),
    .ram_avalid(avalid), .ram_rnw(rnw), .ram_addr(addr), .ram_wdata(wdata),
    .ram_rdata(ram_rdata), .ram_ack(ram_ack),
    .init_done(init_done), .req_dropped(req_dropped)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: array contents plus a queue of reads, each tagged with its due cycle.
  typedef struct {
    int            due;
    logic [WW-1:0] d;
  } exp_t;

  logic [WW-1:0] ref_mem [DEPTH];
  exp_t          exp_q [$];
  int            m_cyc = 0;
  int            m_init_cnt = 0;
  bit            m_ready = 1'b0;
  bit            m_drop = 1'b0;
  bit            m_started = 1'b0;
  logic [WW-1:0] m_last = '0;

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_started  = 1'b1;
        m_ready    = 1'b0;
        m_drop     = 1'b0;
        m_init_cnt = 0;
        m_last     = '0;
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = WW'(i);
      end else if (m_started) begin
        if (!m_ready) begin
          if (avalid) m_drop = 1'b1;
          m_init_cnt++;
          if (m_init_cnt == DEPTH) m_ready = 1'b1;
        end else if (avalid) begin
          if (rnw) exp_q.push_back('{m_cyc + L, ref_mem[addr]});
          else ref_mem[addr] = wdata;
        end
      end
      m_cyc++;
      @(negedge clk);
      if (m_started && errors < 100) begin
        bit e_ack;
        e_ack = (exp_q.size() > 0) && (exp_q[0].due == m_cyc);
        chk("mdl_init_done", init_done, m_ready);
        chk("mdl_req_dropped", req_dropped, m_drop);
        chk("mdl_ack", ram_ack, e_ack);
        if (e_ack) begin
          m_last = exp_q[0].d;
          void'(exp_q.pop_front());
        end
        chk("mdl_rdata", ram_rdata, m_last);
      end
    end
  end

  task automatic step(input logic r, input logic av, input logic rw,
                      input logic [AW-1:0] a, input logic [WW-1:0] d);
    @(posedge clk);
    #1;
    rst = r; avalid = av; rnw = rw; addr = a; wdata = d;
    @(negedge clk);
  endtask

  typedef struct {
    logic          av;
    logic          rw;
    logic [AW-1:0] a;
    logic [WW-1:0] d;
    logic          e_ack;
    logic [WW-1:0] e_rdata;
  } vec_t;

  vec_t vecs [16];

  initial begin
    int rise;
    vecs[0]  = '{1, 1, 13'h0ABC, 16'h0000, 0, 16'h0000};
    vecs[1]  = '{0, 0, 13'h0000, 16'h0000, 0, 16'h0000};
    vecs[2]  = '{0, 0, 13'h0000, 16'h0000, 1, 16'h0ABC};
    vecs[3]  = '{1, 0, 13'h0040, 16'hA5A5, 0, 16'h0ABC};
    vecs[4]  = '{1, 1, 13'h0040, 16'h0000, 0, 16'h0ABC};
    vecs[5]  = '{1, 0, 13'h0040, 16'h5A5A, 0, 16'h0ABC};
    vecs[6]  = '{1, 1, 13'h0040, 16'h0000, 1, 16'hA5A5};
    vecs[7]  = '{1, 1, 13'h0100, 16'h0000, 0, 16'hA5A5};
    vecs[8]  = '{1, 1, 13'h0101, 16'h0000, 1, 16'h5A5A};
    vecs[9]  = '{1, 1, 13'h0102, 16'h0000, 1, 16'h0100};
    vecs[10] = '{1, 1, 13'h0103, 16'h0000, 1, 16'h0101};
    vecs[11] = '{1, 0, 13'h0010, 16'h1234, 1, 16'h0102};
    vecs[12] = '{1, 1, 13'h0010, 16'h0000, 1, 16'h0103};
    vecs[13] = '{0, 0, 13'h0000, 16'h0000, 0, 16'h0103};
    vecs[14] = '{0, 0, 13'h0000, 16'h0000, 1, 16'h1234};
    vecs[15] = '{0, 0, 13'h0000, 16'h0000, 0, 16'h1234};

    for (int i = 0; i < 3; i++) step(1, 0, 0, '0, '0);
    chk("rst_ack", ram_ack, 0);
    chk("rst_rdata", ram_rdata, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_req_dropped", req_dropped, 0);

    // Fill phase with a write issued in cycle 10, which must be dropped.
    for (int c = 0; c <= DEPTH; c++) begin
      if (c == 10) step(0, 1, 0, 13'h0005, 16'hBEEF);
      else step(0, 0, 0, '0, '0);
      if (c == 10) chk("drop_before", req_dropped, 0);
      if (c == 11) chk("drop_after", req_dropped, 1);
      if (c == 11) chk("init_write_no_ack", ram_ack, 0);
      if (c == DEPTH - 1) chk("init_done_last_fill", init_done, 0);
      if (c == DEPTH) chk("init_done_rise", init_done, 1);
    end

    for (int i = 0; i < 16; i++) begin
      step(0, vecs[i].av, vecs[i].rw, vecs[i].a, vecs[i].d);
      chk($sformatf("vec%0d_ack", i), ram_ack, vecs[i].e_ack);
      chk($sformatf("vec%0d_rdata", i), ram_rdata, vecs[i].e_rdata);
    end

    step(0, 1, 1, 13'h0005, '0);
    step(0, 0, 0, '0, '0);
    step(0, 0, 0, '0, '0);
    chk("dropped_write_ack", ram_ack, 1);
    chk("dropped_write_rdata", ram_rdata, 16'h0005);

    for (int i = 0; i < 3000; i++) begin
      logic [AW-1:0] ra;
      ra = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 15)) : AW'($urandom);
      step(0, $urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)), ra, WW'($urandom));
    end
    for (int i = 0; i < L + 2; i++) step(0, 0, 0, '0, '0);

    // Reset the cycle after a read: the read must never be acknowledged.
    step(0, 1, 1, 13'h0020, '0);
    step(1, 0, 0, '0, '0);
    chk("rst_mid_ack", ram_ack, 0);
    rise = -1;
    for (int k = 0; k < DEPTH + 500 && rise < 0; k++) begin
      step(0, 0, 0, '0, '0);
      if (k < 4) chk($sformatf("rst_mid_no_ack%0d", k), ram_ack, 0);
      if (k == 0) chk("rst_mid_rdata", ram_rdata, 0);
      if (k == 0) chk("rst_mid_init_done", init_done, 0);
      if (init_done) rise = k;
    end
    chk("refill_rise_cycle", rise, DEPTH);

    step(0, 1, 1, 13'h0010, '0);
    step(0, 0, 0, '0, '0);
    step(0, 0, 0, '0, '0);
    chk("refill_ack", ram_ack, 1);
    chk("refill_lost_write", ram_rdata, 16'h0010);
    step(0, 0, 0, '0, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
